prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
//  Upstream fetch stage of the 16-bit microcpu: program memory indexed by the core's pc_out,
//  returning the instruction word in the same cycle. Also accepts a byte-stream program image
//  (valid/ready, e.g. from a UART receiver) and writes it into memory while holding the core.
//  Image format: 2-byte word count N (MSB first), then N words, each high byte first.
// PARAMETERS
//  ADDR_W     12       program-counter / memory address width (matches pc_out)
//  DEPTH      4096     words of program memory, = 2**ADDR_W
//  LOAD_BASE  12'h000  address of the first loaded word
//  NOP_INSTR  16'h0000 word driven on instruction while cpu_hold=1
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  reset        in   1       asynchronous, active-low
//  pc_in        in   12      fetch address, from core pc_out
//  instruction  out  16      fetched word, to core instruction
//  load_req     in   1       1-cycle pulse: start receiving an image
//  byte_valid   in   1       byte_data valid
//  byte_data    in   8       stream byte
//  byte_ready   out  1       loader accepts a byte this cycle
//  cpu_hold     out  1       1 while loading; drives core reset
//  load_done    out  1       1-cycle pulse when image complete
//  load_err     out  1       sticky: image exceeded memory space
// BEHAVIOUR
//  Reset (async, reset=0): state=RUN, byte_ready=0, cpu_hold=0, load_done=0, load_err=0,
//   word counter=0, address=LOAD_BASE. Memory contents NOT cleared by reset.
//  Fetch: instruction = mem[pc_in] combinationally (0-cycle latency) when cpu_hold=0;
//   = NOP_INSTR when cpu_hold=1.
//  Handshake: byte accepted on a clk edge where byte_valid & byte_ready. byte_ready=1 in every
//   state except RUN (one byte/cycle sustained). byte_data must hold while valid & !ready.
//  FSM: RUN -(load_req)-> CNT_HI -> CNT_LO -> DAT_HI <-> DAT_LO -> RUN; each arrow except
//   RUN->CNT_HI advances only on an accepted byte.
//   RUN: load_req -> CNT_HI, cpu_hold=1 next cycle, load_err cleared, address=LOAD_BASE.
//   CNT_HI/CNT_LO: assemble 16-bit N. On CNT_LO accept: N=0 -> RUN with load_done pulse,
//    else -> DAT_HI.
//   DAT_HI: latch high byte. DAT_LO accept: if word index < DEPTH-LOAD_BASE write
//    mem[address]={hi,byte_data}, address+1; else discard and set load_err. Decrement N;
//    N reaches 0 -> RUN, load_done=1 for exactly that cycle's following edge, cpu_hold=0.
//  Address never wraps: overflow words consumed (stream stays in sync) but not written.
//  load_req while not in RUN: ignored. load_req and accept in same cycle in RUN: byte not
//   accepted (ready=0 in RUN).
//  Memory write occurs at the edge of the DAT_LO accept; a fetch of that address in the
//   following cycle (after hold drops) returns the new word.
//  Reset mid-load: FSM to RUN immediately, hold released, partially written words remain.
//  Widths: N is 16-bit unsigned; word counter 16-bit; no arithmetic wraps at N=16'hFFFF.
// STRUCTURE
//  Shared include microcpu_defs.vh: ADDR_W, INSTR_W=16, NOP_INSTR encoding, loader state
//   codes (RUN, CNT_HI, CNT_LO, DAT_HI, DAT_LO) used by core and debug logic.
//  Sub-module prog_mem_ram: DEPTH x 16 array, one synchronous write port, one asynchronous
//   read port. FSM, counters and byte assembly stay in prog_mem_loader.
// TESTING
//  1 Reset with pre-initialised mem[5]=16'hA123, pc_in=5 -> instruction=16'hA123, hold=0.
//  2 load_req, bytes 00 02 12 34 AB CD back-to-back -> hold=1 during, mem[0]=1234,
//    mem[1]=ABCD, load_done 1 cycle after final byte, hold=0, err=0.
//  3 Same image with byte_valid toggling every other cycle -> identical result, no byte lost.
//  4 Count 00 00 -> load_done right after CNT_LO byte, memory unchanged.
//  5 LOAD_BASE=12'hFFE, N=3 -> mem[FFE],mem[FFF] written, third word discarded, load_err=1,
//    mem[000] unchanged.
//  6 reset=0 after second data byte of a 2-word load -> hold=0, state RUN, mem[0] written
//    only if its DAT_LO byte was accepted; next load_req restarts cleanly.

Source files
------------

// File: rtl/prog_mem_loader_pkg.sv
// Shared microcpu fetch-stage definitions: widths, NOP encoding and loader state codes.
package prog_mem_loader_pkg;

    localparam int unsigned PM_ADDR_W  = 12;
    localparam int unsigned PM_INSTR_W = 16;
    localparam logic [PM_INSTR_W-1:0] PM_NOP_INSTR = 16'h0000;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DAT_HI = 3'd3,
        DAT_LO = 3'd4
    } ld_state_e;

endpackage

// File: rtl/prog_mem_ram.sv
// Program memory array: one synchronous write port, one asynchronous read port, no reset.
module prog_mem_ram
    import prog_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = PM_ADDR_W,
    parameter int unsigned DEPTH  = 2**PM_ADDR_W,
    parameter int unsigned DATA_W = PM_INSTR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_mem_loader.sv
// Fetch-stage program memory with a byte-stream image loader that holds the core while loading.
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int unsigned                  ADDR_W    = PM_ADDR_W,
    parameter int unsigned                  DEPTH     = 2**PM_ADDR_W,
    parameter logic [ADDR_W-1:0]            LOAD_BASE = '0,
    parameter logic [PM_INSTR_W-1:0]        NOP_INSTR = PM_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     pc_in,
    output logic [PM_INSTR_W-1:0] instruction,
    input  logic                  load_req,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    // Words that fit between LOAD_BASE and the top of memory; beyond this they are dropped.
    localparam int unsigned LOAD_LIMIT = DEPTH - 32'(LOAD_BASE);

    ld_state_e              state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            widx_q, widx_d;
    logic [7:0]             hi_q, hi_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   in_range;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [PM_INSTR_W-1:0]  rd_data;

    assign accept   = byte_valid & byte_ready;
    assign in_range = 32'(widx_q) < LOAD_LIMIT;
    assign wr_addr  = LOAD_BASE + ADDR_W'(widx_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            widx_q  <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        hi_d    = hi_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (load_req) begin
                    state_d = CNT_HI;
                    cnt_d   = '0;
                    widx_d  = '0;
                    err_d   = 1'b0;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    cnt_d[15:8] = byte_data;
                    state_d     = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    cnt_d[7:0] = byte_data;
                    if ({cnt_q[15:8], byte_data} == 16'h0000) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end
            DAT_HI: begin
                if (accept) begin
                    hi_d    = byte_data;
                    state_d = DAT_LO;
                end
            end
            DAT_LO: begin
                if (accept) begin
                    // Overflow words are still counted so the stream stays framed.
                    if (!in_range) begin
                        err_d = 1'b1;
                    end
                    widx_d = widx_q + 16'd1;
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        byte_ready  = (state_q != RUN);
        cpu_hold    = (state_q != RUN);
        wr_en       = (state_q == DAT_LO) && accept && in_range;
        load_done   = done_q;
        load_err    = err_q;
        instruction = cpu_hold ? NOP_INSTR : rd_data;
    end

    prog_mem_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (PM_INSTR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i ({hi_q, byte_data}),
        .raddr_i (pc_in),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomised scoreboard bench: two loaders (base 000 and FFE) fed the same image stream.
module tb_prog_mem_loader;
    import prog_mem_loader_pkg::*;

    localparam logic [11:0] BASE_A = 12'h000;
    localparam logic [11:0] BASE_B = 12'hFFE;
    localparam logic [15:0] NOP    = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] pc_in;
    logic        load_req, byte_valid;
    logic [7:0]  byte_data;
    logic [15:0] ins_a, ins_b;
    logic        rdy_a, rdy_b, hold_a, hold_b, done_a, done_b, err_a, err_b;

    always #5 clk = ~clk;

    prog_mem_loader #(.LOAD_BASE(BASE_A)) u_a (
        .clk(clk), .reset(reset_n), .pc_in(pc_in), .instruction(ins_a),
        .load_req(load_req), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(rdy_a), .cpu_hold(hold_a), .load_done(done_a), .load_err(err_a)
    );

    prog_mem_loader #(.LOAD_BASE(BASE_B)) u_b (
        .clk(clk), .reset(reset_n), .pc_in(pc_in), .instruction(ins_b),
        .load_req(load_req), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(rdy_b), .cpu_hold(hold_b), .load_done(done_b), .load_err(err_b)
    );

    typedef struct packed { logic err_a; logic err_b; } done_t;
    typedef struct {
        logic [11:0] pc;
        bit          chk_a, chk_b;
        logic [15:0] ins_a, ins_b;
        logic        hold, err_a, err_b;
    } probe_t;

    done_t  done_q[$];
    probe_t probe_q[$];
    logic   probe_stb;

    // Reference model: what each memory should hold, and which words are known.
    logic [15:0] mem_a [4096];
    logic [15:0] mem_b [4096];
    bit          kn_a  [4096];
    bit          kn_b  [4096];
    logic        err_a_m, err_b_m, exp_hold;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: every cycle checks hold, pops done/probe expectations when the DUT presents them.
    always @(negedge clk) begin
        done_t  d;
        probe_t p;
        chk1("hold_a", hold_a, exp_hold);
        chk1("hold_b", hold_b, exp_hold);
        if (done_a || done_b) begin
            if (done_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done_a=%b done_b=%b expected none", done_a, done_b);
            end else begin
                d = done_q.pop_front();
                chk1("done_a", done_a, 1'b1);
                chk1("done_b", done_b, 1'b1);
                chk1("done_err_a", err_a, d.err_a);
                chk1("done_err_b", err_b, d.err_b);
            end
        end
        if (probe_stb) begin
            if (probe_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL probe_queue: got strobe expected queued probe");
            end else begin
                p = probe_q.pop_front();
                chk1("probe_hold", hold_a, p.hold);
                chk1("probe_ready_a", rdy_a, p.hold);
                chk1("probe_ready_b", rdy_b, p.hold);
                chk1("probe_err_a", err_a, p.err_a);
                chk1("probe_err_b", err_b, p.err_b);
                if (p.chk_a) chk16($sformatf("ins_a[%h]", p.pc), ins_a, p.ins_a);
                if (p.chk_b) chk16($sformatf("ins_b[%h]", p.pc), ins_b, p.ins_b);
            end
        end
    end

    task automatic probe(input logic [11:0] pc);
        probe_t p;
        pc_in   = pc;
        p.pc    = pc;
        p.chk_a = exp_hold || kn_a[pc];
        p.chk_b = exp_hold || kn_b[pc];
        p.ins_a = exp_hold ? NOP : mem_a[pc];
        p.ins_b = exp_hold ? NOP : mem_b[pc];
        p.hold  = exp_hold;
        p.err_a = err_a_m;
        p.err_b = err_b_m;
        probe_q.push_back(p);
        probe_stb = 1'b1;
        @(posedge clk); #1;
        probe_stb = 1'b0;
    endtask

    function automatic logic [11:0] rand_pc();
        logic [11:0] r;
        case ($urandom_range(0, 3))
            0: r = 12'hFFE + 12'($urandom_range(0, 1));
            1: r = 12'($urandom);
            default: r = 12'($urandom_range(0, 7));
        endcase
        return r;
    endfunction

    task automatic do_reset();
        reset_n    = 1'b0;
        load_req   = 1'b0;
        byte_valid = 1'b0;
        exp_hold   = 1'b0;
        err_a_m    = 1'b0;
        err_b_m    = 1'b0;
        @(posedge clk); #1;
        probe(rand_pc());
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit spur, output bit ok);
        ok         = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        load_req   = spur;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (rdy_a) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        byte_valid = 1'b0;
        load_req   = 1'b0;
        byte_data  = 8'($urandom);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept_timeout: got no ready expected byte %h accepted", b);
        end
    endtask

    // Word w lands at base+w only if that address exists; otherwise it sets the error flag.
    function automatic void model_word(input int unsigned w, input logic [15:0] val);
        int unsigned addr;
        addr = int'(BASE_A) + w;
        if (addr < 4096) begin mem_a[addr] = val; kn_a[addr] = 1'b1; end
        else err_a_m = 1'b1;
        addr = int'(BASE_B) + w;
        if (addr < 4096) begin mem_b[addr] = val; kn_b[addr] = 1'b1; end
        else err_b_m = 1'b1;
    endfunction

    // mode 0: back-to-back, 1: one idle cycle between bytes, 2: random gaps/probes/spurious load_req.
    task automatic load_image(input logic [15:0] words[$], input int mode, input int abort_at);
        logic [7:0]  bytes[$];
        logic [15:0] n;
        done_t       d;
        bit          ok;
        n = 16'(words.size());
        bytes.push_back(n[15:8]);
        bytes.push_back(n[7:0]);
        foreach (words[k]) begin
            bytes.push_back(words[k][15:8]);
            bytes.push_back(words[k][7:0]);
        end
        d.err_a = (int'(n) > 4096 - int'(BASE_A));
        d.err_b = (int'(n) > 4096 - int'(BASE_B));

        @(posedge clk); #1;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        exp_hold = 1'b1;
        err_a_m  = 1'b0;
        err_b_m  = 1'b0;

        for (int i = 0; i < bytes.size(); i++) begin
            if (mode == 1 && i > 0) begin
                @(posedge clk); #1;
            end else if (mode == 2) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    if ($urandom_range(0, 1) == 1) probe(rand_pc());
                    else begin @(posedge clk); #1; end
                end
            end
            if (i == bytes.size() - 1) done_q.push_back(d);
            send_byte(bytes[i], (mode == 2) && ($urandom_range(0, 7) == 0), ok);
            if (!ok) begin
                do_reset();
                void'(done_q.pop_back());
                return;
            end
            if (i >= 3 && (i % 2) == 1) model_word(int'((i - 3) / 2), words[(i - 3) / 2]);
            if (i + 1 == abort_at) begin
                do_reset();
                return;
            end
        end
        exp_hold = 1'b0;
    endtask

    initial begin
        logic [15:0] w[$];
        int          n, mode, ab;
        reset_n    = 1'b0;
        load_req   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        pc_in      = '0;
        probe_stb  = 1'b0;
        exp_hold   = 1'b0;
        err_a_m    = 1'b0;
        err_b_m    = 1'b0;
        foreach (kn_a[k]) begin kn_a[k] = 1'b0; kn_b[k] = 1'b0; end

        repeat (2) @(posedge clk);
        #1;
        probe(12'h005);
        reset_n = 1'b1;
        @(posedge clk); #1;

        w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'hA123};
        load_image(w, 0, 0);
        probe(12'h005); probe(12'h000); probe(12'hFFE); probe(12'hFFF);

        w = '{16'h1234, 16'hABCD};
        load_image(w, 0, 0);
        probe(12'h000); probe(12'h001); probe(12'hFFE); probe(12'hFFF);

        w = '{16'h5A5A, 16'hC3C3};
        load_image(w, 1, 0);
        probe(12'h000); probe(12'h001); probe(12'h005);

        w.delete();
        load_image(w, 0, 0);
        probe(12'h000); probe(12'h001); probe(12'h005);

        w = '{16'($urandom), 16'($urandom), 16'($urandom)};
        load_image(w, 2, 0);
        probe(12'hFFE); probe(12'hFFF); probe(12'h002);

        w = '{16'hBEEF, 16'hF00D};
        load_image(w, 0, 4);
        probe(12'h000); probe(12'h001);
        w = '{16'hDEAD, 16'h7777};
        load_image(w, 0, 3);
        probe(12'h000); probe(12'h001);
        w = '{16'h0F0F, 16'hF0F0};
        load_image(w, 2, 0);
        probe(12'h000); probe(12'h001);

        for (int it = 0; it < 25; it++) begin
            n = int'($urandom_range(0, 6));
            w.delete();
            for (int k = 0; k < n; k++) w.push_back(16'($urandom));
            mode = int'($urandom_range(0, 2));
            ab = 0;
            if (n > 0 && $urandom_range(0, 4) == 0) ab = int'($urandom_range(1, 2 * n + 1));
            load_image(w, mode, ab);
            repeat (3) probe(rand_pc());
        end

        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (done_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_done: got %0d missing load_done pulses expected 0", done_q.size());
        end
        vectors++;
        if (probe_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_probe: got %0d unchecked probes expected 0", probe_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
